// File: rtl/alu_pkg.sv
// Shared definitions for the field ALU and its control stages: op codes,
// exponent width and the inversion-exponent bit lookup.
package alu_pkg;

    typedef enum logic [1:0] {
        OP_PRECAL = 2'd0,
        OP_DOUBLE = 2'd1,
        OP_DIVINV = 2'd2,
        OP_DIVMUL = 2'd3
    } alu_op_t;

    localparam int EXP_BITS = 255;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_ISSUE,
        S_WAIT,
        S_FISSUE,
        S_FWAIT,
        S_DONE
    } inv_state_t;

    // Low five bits of q-2 = 2^255-21; every bit from 5 upward is one.
    localparam logic [4:0] EXP_LOW_BITS = 5'b01011;

    function automatic logic ebit(input logic [7:0] i);
        if (i >= 8'd5) begin
            return 1'b1;
        end
        return EXP_LOW_BITS[i[2:0]];
    endfunction

endpackage

// File: rtl/inv_sequencer.sv
// Fermat-inversion sequencer: walks the exponent q-2 MSB first, issuing one
// DIV-INV op per bit and a closing DIV-MUL op, with an ALU response timeout.
module inv_sequencer #(
    parameter int EXP_BITS = alu_pkg::EXP_BITS,
    parameter int TIMEOUT  = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       alu_ready,
    output logic       alu_valid,
    output logic [1:0] alu_state,
    output logic       alu_consecutive_flag,
    output logic       lut_init_we,
    output logic       busy,
    output logic       done,
    output logic       err
);
    import alu_pkg::*;

    inv_state_t state_reg, state_next;
    logic [7:0] idx_reg, idx_next;
    logic [3:0] tcnt_reg, tcnt_next;
    logic       err_reg, err_next;
    alu_op_t    op_sel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
            idx_reg   <= '0;
            tcnt_reg  <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            tcnt_reg  <= tcnt_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next           = state_reg;
        idx_next             = idx_reg;
        tcnt_next            = '0;
        err_next             = err_reg;
        alu_valid            = 1'b0;
        op_sel               = OP_DIVINV;
        alu_consecutive_flag = 1'b0;
        lut_init_we          = 1'b0;
        done                 = 1'b0;

        unique case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next = S_INIT;
                    idx_next   = 8'(EXP_BITS - 1);
                    err_next   = 1'b0;
                end
            end
            S_INIT: begin
                lut_init_we = 1'b1;
                state_next  = S_ISSUE;
            end
            S_ISSUE: begin
                alu_valid            = 1'b1;
                alu_consecutive_flag = ebit(idx_reg);
                state_next           = S_WAIT;
            end
            S_WAIT: begin
                // The ALU samples the flag mid-op, so it must hold through WAIT.
                alu_consecutive_flag = ebit(idx_reg);
                if (alu_ready) begin
                    if (idx_reg == 8'd0) begin
                        state_next = S_FISSUE;
                    end else begin
                        idx_next   = idx_reg - 8'd1;
                        state_next = S_ISSUE;
                    end
                end else if (tcnt_reg == 4'(TIMEOUT - 1)) begin
                    err_next   = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    tcnt_next = tcnt_reg + 4'd1;
                end
            end
            S_FISSUE: begin
                alu_valid  = 1'b1;
                op_sel     = OP_DIVMUL;
                state_next = S_FWAIT;
            end
            S_FWAIT: begin
                op_sel = OP_DIVMUL;
                if (alu_ready) begin
                    state_next = S_DONE;
                end else if (tcnt_reg == 4'(TIMEOUT - 1)) begin
                    err_next   = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    tcnt_next = tcnt_reg + 4'd1;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign alu_state = op_sel;
    assign busy      = (state_reg != S_IDLE);
    assign err       = err_reg;

endmodule
